// File: rtl/ysyx_22050710_axil_rr_arbiter.sv
// ============================================================================
// ysyx_22050710_axil_rr_arbiter : 2-master to 1-slave AXI4-Lite arbiter with
// independent read/write round-robin arbitration. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_22050710_axil_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  // master A
  input  logic                  i_a_awvalid,
  output logic                  o_a_awready,
  input  logic [ADDR_WIDTH-1:0] i_a_awaddr,
  input  logic [2:0]            i_a_awprot,
  input  logic                  i_a_wvalid,
  output logic                  o_a_wready,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic [STRB_WIDTH-1:0] i_a_wstrb,
  output logic                  o_a_bvalid,
  input  logic                  i_a_bready,
  output logic [1:0]            o_a_bresp,
  input  logic                  i_a_arvalid,
  output logic                  o_a_arready,
  input  logic [ADDR_WIDTH-1:0] i_a_araddr,
  input  logic [2:0]            i_a_arprot,
  output logic                  o_a_rvalid,
  input  logic                  i_a_rready,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic [1:0]            o_a_rresp,
  // master B
  input  logic                  i_b_awvalid,
  output logic                  o_b_awready,
  input  logic [ADDR_WIDTH-1:0] i_b_awaddr,
  input  logic [2:0]            i_b_awprot,
  input  logic                  i_b_wvalid,
  output logic                  o_b_wready,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  input  logic [STRB_WIDTH-1:0] i_b_wstrb,
  output logic                  o_b_bvalid,
  input  logic                  i_b_bready,
  output logic [1:0]            o_b_bresp,
  input  logic                  i_b_arvalid,
  output logic                  o_b_arready,
  input  logic [ADDR_WIDTH-1:0] i_b_araddr,
  input  logic [2:0]            i_b_arprot,
  output logic                  o_b_rvalid,
  input  logic                  i_b_rready,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic [1:0]            o_b_rresp,
  // slave
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [2:0]            o_awprot,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [2:0]            o_arprot,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} rd_state_t;

  // Grant encoding: 0 = master A, 1 = master B
  localparam logic c_GNT_B = 1'b1;

  wr_state_t r_wr_state_q, w_wr_state_d;
  rd_state_t r_rd_state_q, w_rd_state_d;
  logic      r_wr_gnt_q,  w_wr_gnt_d;
  logic      r_wr_last_q, w_wr_last_d;
  logic      r_rd_gnt_q,  w_rd_gnt_d;
  logic      r_rd_last_q, w_rd_last_d;
  logic      r_aw_done_q, w_aw_done_d;
  logic      r_w_done_q,  w_w_done_d;

  // Outputs are forced low while reset is held, even mid-transaction.
  logic w_live;
  logic w_wr_req, w_wr_resp, w_rd_req, w_rd_resp;
  logic w_wr_sel_b, w_rd_sel_b;
  logic w_wr_pick, w_rd_pick;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_live     = ~i_areset;
  assign w_wr_req   = w_live & (r_wr_state_q == W_REQ);
  assign w_wr_resp  = w_live & (r_wr_state_q == W_RESP);
  assign w_rd_req   = w_live & (r_rd_state_q == R_REQ);
  assign w_rd_resp  = w_live & (r_rd_state_q == R_RESP);
  assign w_wr_sel_b = r_wr_gnt_q;
  assign w_rd_sel_b = r_rd_gnt_q;

  // A lone requester wins; on a tie the master not granted last wins.
  assign w_wr_pick = (i_a_awvalid & i_b_awvalid) ? ~r_wr_last_q : i_b_awvalid;
  assign w_rd_pick = (i_a_arvalid & i_b_arvalid) ? ~r_rd_last_q : i_b_arvalid;

  // Write address / data forwarding
  assign o_awvalid = w_wr_req & ~r_aw_done_q & (w_wr_sel_b ? i_b_awvalid : i_a_awvalid);
  assign o_awaddr  = w_wr_req ? (w_wr_sel_b ? i_b_awaddr : i_a_awaddr) : '0;
  assign o_awprot  = w_wr_req ? (w_wr_sel_b ? i_b_awprot : i_a_awprot) : '0;
  assign o_wvalid  = w_wr_req & ~r_w_done_q & (w_wr_sel_b ? i_b_wvalid : i_a_wvalid);
  assign o_wdata   = w_wr_req ? (w_wr_sel_b ? i_b_wdata : i_a_wdata) : '0;
  assign o_wstrb   = w_wr_req ? (w_wr_sel_b ? i_b_wstrb : i_a_wstrb) : '0;

  assign o_a_awready = w_wr_req & ~w_wr_sel_b & ~r_aw_done_q & i_awready;
  assign o_b_awready = w_wr_req &  w_wr_sel_b & ~r_aw_done_q & i_awready;
  assign o_a_wready  = w_wr_req & ~w_wr_sel_b & ~r_w_done_q  & i_wready;
  assign o_b_wready  = w_wr_req &  w_wr_sel_b & ~r_w_done_q  & i_wready;

  // Write response routing
  assign o_bready   = w_wr_resp & (w_wr_sel_b ? i_b_bready : i_a_bready);
  assign o_a_bvalid = w_wr_resp & ~w_wr_sel_b & i_bvalid;
  assign o_b_bvalid = w_wr_resp &  w_wr_sel_b & i_bvalid;
  assign o_a_bresp  = (w_wr_resp & ~w_wr_sel_b) ? i_bresp : 2'b00;
  assign o_b_bresp  = (w_wr_resp &  w_wr_sel_b) ? i_bresp : 2'b00;

  // Read address forwarding and response routing
  assign o_arvalid   = w_rd_req & (w_rd_sel_b ? i_b_arvalid : i_a_arvalid);
  assign o_araddr    = w_rd_req ? (w_rd_sel_b ? i_b_araddr : i_a_araddr) : '0;
  assign o_arprot    = w_rd_req ? (w_rd_sel_b ? i_b_arprot : i_a_arprot) : '0;
  assign o_a_arready = w_rd_req & ~w_rd_sel_b & i_arready;
  assign o_b_arready = w_rd_req &  w_rd_sel_b & i_arready;

  assign o_rready   = w_rd_resp & (w_rd_sel_b ? i_b_rready : i_a_rready);
  assign o_a_rvalid = w_rd_resp & ~w_rd_sel_b & i_rvalid;
  assign o_b_rvalid = w_rd_resp &  w_rd_sel_b & i_rvalid;
  assign o_a_rdata  = (w_rd_resp & ~w_rd_sel_b) ? i_rdata : '0;
  assign o_b_rdata  = (w_rd_resp &  w_rd_sel_b) ? i_rdata : '0;
  assign o_a_rresp  = (w_rd_resp & ~w_rd_sel_b) ? i_rresp : 2'b00;
  assign o_b_rresp  = (w_rd_resp &  w_rd_sel_b) ? i_rresp : 2'b00;

  assign w_aw_hs = o_awvalid & i_awready;
  assign w_w_hs  = o_wvalid  & i_wready;
  assign w_b_hs  = i_bvalid  & o_bready;
  assign w_ar_hs = o_arvalid & i_arready;
  assign w_r_hs  = i_rvalid  & o_rready;

  always_comb begin
    w_wr_state_d = r_wr_state_q;
    w_wr_gnt_d   = r_wr_gnt_q;
    w_wr_last_d  = r_wr_last_q;
    w_aw_done_d  = r_aw_done_q;
    w_w_done_d   = r_w_done_q;
    case (r_wr_state_q)
      W_IDLE: begin
        if (i_a_awvalid | i_b_awvalid) begin
          w_wr_gnt_d   = w_wr_pick;
          w_wr_last_d  = w_wr_pick;
          w_wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W may complete in either order or together.
        w_aw_done_d = r_aw_done_q | w_aw_hs;
        w_w_done_d  = r_w_done_q  | w_w_hs;
        if (w_aw_done_d & w_w_done_d) w_wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_aw_done_d  = 1'b0;
          w_w_done_d   = 1'b0;
          w_wr_state_d = W_IDLE;
        end
      end
      default: w_wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_d = r_rd_state_q;
    w_rd_gnt_d   = r_rd_gnt_q;
    w_rd_last_d  = r_rd_last_q;
    case (r_rd_state_q)
      R_IDLE: begin
        if (i_a_arvalid | i_b_arvalid) begin
          w_rd_gnt_d   = w_rd_pick;
          w_rd_last_d  = w_rd_pick;
          w_rd_state_d = R_REQ;
        end
      end
      R_REQ:   if (w_ar_hs) w_rd_state_d = R_RESP;
      R_RESP:  if (w_r_hs)  w_rd_state_d = R_IDLE;
      default: w_rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_wr_state_q <= W_IDLE;
      r_rd_state_q <= R_IDLE;
      r_wr_gnt_q   <= 1'b0;
      r_rd_gnt_q   <= 1'b0;
      r_wr_last_q  <= c_GNT_B;
      r_rd_last_q  <= c_GNT_B;
      r_aw_done_q  <= 1'b0;
      r_w_done_q   <= 1'b0;
    end else begin
      r_wr_state_q <= w_wr_state_d;
      r_rd_state_q <= w_rd_state_d;
      r_wr_gnt_q   <= w_wr_gnt_d;
      r_rd_gnt_q   <= w_rd_gnt_d;
      r_wr_last_q  <= w_wr_last_d;
      r_rd_last_q  <= w_rd_last_d;
      r_aw_done_q  <= w_aw_done_d;
      r_w_done_q   <= w_w_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_axil_rr_arbiter.sv
// ============================================================================
// tb_ysyx_22050710_axil_rr_arbiter : directed bench for the AXI4-Lite arbiter.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_22050710_axil_rr_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic i_areset;
  logic a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic a_arvalid, a_arready, a_rvalid, a_rready;
  logic [AW-1:0] a_awaddr, a_araddr;
  logic [2:0] a_awprot, a_arprot;
  logic [DW-1:0] a_wdata, a_rdata;
  logic [SW-1:0] a_wstrb;
  logic [1:0] a_bresp, a_rresp;
  logic b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic b_arvalid, b_arready, b_rvalid, b_rready;
  logic [AW-1:0] b_awaddr, b_araddr;
  logic [2:0] b_awprot, b_arprot;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [SW-1:0] b_wstrb;
  logic [1:0] b_bresp, b_rresp;
  logic o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic o_arvalid, i_arready, i_rvalid, o_rready;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [2:0] o_awprot, o_arprot;
  logic [DW-1:0] o_wdata, i_rdata;
  logic [SW-1:0] o_wstrb;
  logic [1:0] i_bresp, i_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050710_axil_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .i_aclk(clk), .i_areset(i_areset),
    .i_a_awvalid(a_awvalid), .o_a_awready(a_awready), .i_a_awaddr(a_awaddr), .i_a_awprot(a_awprot),
    .i_a_wvalid(a_wvalid), .o_a_wready(a_wready), .i_a_wdata(a_wdata), .i_a_wstrb(a_wstrb),
    .o_a_bvalid(a_bvalid), .i_a_bready(a_bready), .o_a_bresp(a_bresp),
    .i_a_arvalid(a_arvalid), .o_a_arready(a_arready), .i_a_araddr(a_araddr), .i_a_arprot(a_arprot),
    .o_a_rvalid(a_rvalid), .i_a_rready(a_rready), .o_a_rdata(a_rdata), .o_a_rresp(a_rresp),
    .i_b_awvalid(b_awvalid), .o_b_awready(b_awready), .i_b_awaddr(b_awaddr), .i_b_awprot(b_awprot),
    .i_b_wvalid(b_wvalid), .o_b_wready(b_wready), .i_b_wdata(b_wdata), .i_b_wstrb(b_wstrb),
    .o_b_bvalid(b_bvalid), .i_b_bready(b_bready), .o_b_bresp(b_bresp),
    .i_b_arvalid(b_arvalid), .o_b_arready(b_arready), .i_b_araddr(b_araddr), .i_b_arprot(b_arprot),
    .o_b_rvalid(b_rvalid), .i_b_rready(b_rready), .o_b_rdata(b_rdata), .o_b_rresp(b_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    a_awvalid = 0; a_awaddr = '0; a_awprot = '0; a_wvalid = 0; a_wdata = '0; a_wstrb = '0;
    a_bready = 0; a_arvalid = 0; a_araddr = '0; a_arprot = '0; a_rready = 0;
    b_awvalid = 0; b_awaddr = '0; b_awprot = '0; b_wvalid = 0; b_wdata = '0; b_wstrb = '0;
    b_bready = 0; b_arvalid = 0; b_araddr = '0; b_arprot = '0; b_rready = 0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = '0;
    i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = '0;
  endtask

  // Leaves the caller in the first cycle after reset release.
  task automatic do_reset;
    clear_inputs();
    i_areset = 1;
    step();
    step();
    i_areset = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    i_areset = 1;
    a_arvalid = 1; b_arvalid = 1; a_awvalid = 1; b_awvalid = 1; a_wvalid = 1; b_wvalid = 1;
    a_araddr = 32'h8000_0000; b_araddr = 32'h8000_0100;
    i_arready = 1; i_awready = 1; i_wready = 1; i_rvalid = 1; i_bvalid = 1;
    i_rdata = 64'hFFFF_FFFF; i_bresp = 2'b11;
    a_rready = 1; b_rready = 1; a_bready = 1; b_bready = 1;
    step(); step();
    n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_o_arvalid: got %0h expected 0", o_arvalid); end
    n_checks++; if (o_awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_o_awvalid: got %0h expected 0", o_awvalid); end
    n_checks++; if (o_wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_o_wvalid: got %0h expected 0", o_wvalid); end
    n_checks++; if (o_rready !== 1'b0 || o_bready !== 1'b0) begin n_fail++; $display("FAIL rst_slave_readies: got %0h%0h expected 00", o_rready, o_bready); end
    n_checks++; if ({a_arready, b_arready, a_awready, b_awready, a_wready, b_wready} !== 6'b0) begin n_fail++; $display("FAIL rst_master_readies: got %b expected 000000", {a_arready, b_arready, a_awready, b_awready, a_wready, b_wready}); end
    n_checks++; if ({a_rvalid, b_rvalid, a_bvalid, b_bvalid} !== 4'b0) begin n_fail++; $display("FAIL rst_master_valids: got %b expected 0000", {a_rvalid, b_rvalid, a_bvalid, b_bvalid}); end
    n_checks++; if (a_rdata !== 64'h0 || a_bresp !== 2'b00) begin n_fail++; $display("FAIL rst_a_rdata_bresp: got %0h/%0h expected 0/0", a_rdata, a_bresp); end
    // keep only the read requests alive across release
    a_awvalid = 0; b_awvalid = 0; a_wvalid = 0; b_wvalid = 0;
    i_arready = 0; i_rvalid = 0; i_bvalid = 0;
    step();
    i_areset = 0;
    #1;
    n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_release_arvalid: got %0h expected 0", o_arvalid); end
    step();
    n_checks++; if (o_arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_first_arvalid: got %0h expected 1", o_arvalid); end
    n_checks++; if (o_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_first_araddr: got %0h expected 80000000", o_araddr); end
    do_reset();
  endtask

  task automatic test_read_tie;
    a_araddr = 32'h8000_0000; b_araddr = 32'h8000_0100;
    a_arvalid = 1; b_arvalid = 1; a_rready = 1; b_rready = 1; i_arready = 1;
    #1;
    n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL tie_arb_cycle: got %0h expected 0", o_arvalid); end
    step();
    n_checks++; if (o_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL tie_a_araddr: got %0h expected 80000000", o_araddr); end
    n_checks++; if (a_arready !== 1'b1 || b_arready !== 1'b0) begin n_fail++; $display("FAIL tie_a_arready: got a=%0h b=%0h expected a=1 b=0", a_arready, b_arready); end
    step();
    a_arvalid = 0; i_rvalid = 1; i_rdata = 64'h11;
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h11) begin n_fail++; $display("FAIL tie_a_rbeat: got v=%0h d=%0h expected v=1 d=11", a_rvalid, a_rdata); end
    n_checks++; if (b_rvalid !== 1'b0 || b_rdata !== 64'h0) begin n_fail++; $display("FAIL tie_b_quiet: got v=%0h d=%0h expected v=0 d=0", b_rvalid, b_rdata); end
    step();
    i_rvalid = 0;
    #1;
    n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL tie_idle_gap: got %0h expected 0", o_arvalid); end
    step();
    n_checks++; if (o_araddr !== 32'h8000_0100 || b_arready !== 1'b1 || a_arready !== 1'b0) begin n_fail++; $display("FAIL tie_b_grant: got addr=%0h a=%0h b=%0h expected addr=80000100 a=0 b=1", o_araddr, a_arready, b_arready); end
    step();
    b_arvalid = 0; i_rvalid = 1; i_rdata = 64'h22;
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 64'h22) begin n_fail++; $display("FAIL tie_b_rbeat: got v=%0h d=%0h expected v=1 d=22", b_rvalid, b_rdata); end
    n_checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0) begin n_fail++; $display("FAIL tie_a_quiet: got v=%0h d=%0h expected v=0 d=0", a_rvalid, a_rdata); end
    step();
    i_rvalid = 0;
    #1;
  endtask

  task automatic test_round_robin;
    logic exp_b;
    a_araddr = 32'h8000_1000; b_araddr = 32'h8000_2000;
    a_arvalid = 1; b_arvalid = 1; i_arready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2) == 1;
      step();
      n_checks++; if (a_arready !== ~exp_b || b_arready !== exp_b) begin n_fail++; $display("FAIL rr_grant_%0d: got a=%0h b=%0h expected a=%0h b=%0h", i, a_arready, b_arready, ~exp_b, exp_b); end
      n_checks++; if (o_araddr !== (exp_b ? 32'h8000_2000 : 32'h8000_1000)) begin n_fail++; $display("FAIL rr_addr_%0d: got %0h expected %0h", i, o_araddr, exp_b ? 32'h8000_2000 : 32'h8000_1000); end
      step();
      i_rvalid = 1; i_rdata = 64'(i + 1);
      #1;
      n_checks++; if ((exp_b ? b_rvalid : a_rvalid) !== 1'b1 || (exp_b ? a_rvalid : b_rvalid) !== 1'b0) begin n_fail++; $display("FAIL rr_route_%0d: got a=%0h b=%0h expected granted only", i, a_rvalid, b_rvalid); end
      step();
      i_rvalid = 0;
      #1;
    end
    a_arvalid = 0; b_arvalid = 0; i_arready = 0;
    #1;
  endtask

  task automatic test_write_order;
    a_wvalid = 1; a_wdata = 64'h0123_4567_89AB_CDEF; a_wstrb = 8'hFF; a_bready = 1;
    i_wready = 1; i_awready = 0;
    #1;
    n_checks++; if (a_wready !== 1'b0 || o_wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_early_w_held: got wready=%0h wvalid=%0h expected 0/0", a_wready, o_wvalid); end
    step();
    step();
    a_awvalid = 1; a_awaddr = 32'h8000_0040;
    #1;
    n_checks++; if (o_awvalid !== 1'b0) begin n_fail++; $display("FAIL wr_arb_cycle: got %0h expected 0", o_awvalid); end
    step();
    n_checks++; if (o_wvalid !== 1'b1 || o_wstrb !== 8'hFF || o_wdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL wr_w_fwd: got v=%0h s=%0h d=%0h expected 1/ff/0123456789abcdef", o_wvalid, o_wstrb, o_wdata); end
    n_checks++; if (a_wready !== 1'b1 || o_awvalid !== 1'b1 || a_awready !== 1'b0) begin n_fail++; $display("FAIL wr_w_first: got wready=%0h awvalid=%0h awready=%0h expected 1/1/0", a_wready, o_awvalid, a_awready); end
    step();
    a_wvalid = 0;
    #1;
    n_checks++; if (o_wvalid !== 1'b0 || a_wready !== 1'b0 || o_awvalid !== 1'b1 || o_bready !== 1'b0) begin n_fail++; $display("FAIL wr_wait_aw: got wv=%0h wr=%0h awv=%0h br=%0h expected 0/0/1/0", o_wvalid, a_wready, o_awvalid, o_bready); end
    i_awready = 1;
    #1;
    n_checks++; if (a_awready !== 1'b1 || o_awaddr !== 32'h8000_0040) begin n_fail++; $display("FAIL wr_aw_accept: got r=%0h addr=%0h expected 1/80000040", a_awready, o_awaddr); end
    step();
    a_awvalid = 0; i_awready = 0; i_bvalid = 1; i_bresp = 2'b00;
    #1;
    n_checks++; if (a_bvalid !== 1'b1 || a_bresp !== 2'b00 || b_bvalid !== 1'b0 || o_bready !== 1'b1) begin n_fail++; $display("FAIL wr_b_route: got av=%0h ar=%0h bv=%0h rdy=%0h expected 1/0/0/1", a_bvalid, a_bresp, b_bvalid, o_bready); end
    step();
    i_bvalid = 0; i_wready = 0;
    #1;
    n_checks++; if (o_awvalid !== 1'b0 || a_bvalid !== 1'b0 || o_bready !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle: got awv=%0h bv=%0h br=%0h expected 0/0/0", o_awvalid, a_bvalid, o_bready); end
  endtask

  task automatic test_concurrency;
    a_arvalid = 1; a_araddr = 32'h8000_3000; a_rready = 1;
    b_awvalid = 1; b_awaddr = 32'h1000_0000; b_wvalid = 1; b_wdata = 64'h55AA; b_wstrb = 8'h0F; b_bready = 1;
    i_arready = 1; i_awready = 1; i_wready = 1;
    #1;
    step();
    n_checks++; if (a_arready !== 1'b1 || b_awready !== 1'b1 || b_wready !== 1'b1 || a_awready !== 1'b0 || b_arready !== 1'b0) begin n_fail++; $display("FAIL cc_grants: got ar_a=%0h aw_b=%0h w_b=%0h aw_a=%0h ar_b=%0h expected 1/1/1/0/0", a_arready, b_awready, b_wready, a_awready, b_arready); end
    n_checks++; if (o_awaddr !== 32'h1000_0000 || o_araddr !== 32'h8000_3000 || o_wstrb !== 8'h0F) begin n_fail++; $display("FAIL cc_addrs: got aw=%0h ar=%0h s=%0h expected 10000000/80003000/0f", o_awaddr, o_araddr, o_wstrb); end
    step();
    a_arvalid = 0; b_awvalid = 0; b_wvalid = 0; i_arready = 0; i_awready = 0; i_wready = 0;
    i_rvalid = 1; i_rdata = 64'hDEAD; i_bvalid = 1; i_bresp = 2'b10;
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'hDEAD) begin n_fail++; $display("FAIL cc_a_read: got v=%0h d=%0h expected 1/dead", a_rvalid, a_rdata); end
    n_checks++; if (b_bvalid !== 1'b1 || b_bresp !== 2'b10) begin n_fail++; $display("FAIL cc_b_slverr: got v=%0h r=%0h expected 1/2", b_bvalid, b_bresp); end
    n_checks++; if (a_bvalid !== 1'b0 || a_bresp !== 2'b00 || b_rvalid !== 1'b0 || b_rdata !== 64'h0) begin n_fail++; $display("FAIL cc_no_cross: got abv=%0h abr=%0h brv=%0h brd=%0h expected 0/0/0/0", a_bvalid, a_bresp, b_rvalid, b_rdata); end
    step();
    i_rvalid = 0; i_bvalid = 0; i_bresp = 2'b00;
    #1;
  endtask

  task automatic test_mid_reset;
    a_arvalid = 1; a_araddr = 32'h8000_4000; a_rready = 0; i_arready = 1;
    #1;
    step();
    n_checks++; if (a_arready !== 1'b1) begin n_fail++; $display("FAIL mr_grant: got %0h expected 1", a_arready); end
    step();
    a_arvalid = 0; i_arready = 0; i_rvalid = 1; i_rdata = 64'h55;
    #1;
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL mr_rvalid_before: got %0h expected 1", a_rvalid); end
    step();
    i_areset = 1;
    #1;
    n_checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0) begin n_fail++; $display("FAIL mr_rvalid_in_reset: got v=%0h d=%0h expected 0/0", a_rvalid, a_rdata); end
    step();
    i_areset = 0; i_rvalid = 0;
    a_arvalid = 1; b_arvalid = 1; a_araddr = 32'h8000_5000; b_araddr = 32'h8000_6000; i_arready = 1;
    #1;
    n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL mr_idle_after: got %0h expected 0", o_arvalid); end
    step();
    n_checks++; if (a_arready !== 1'b1 || b_arready !== 1'b0 || o_araddr !== 32'h8000_5000) begin n_fail++; $display("FAIL mr_a_favored: got a=%0h b=%0h addr=%0h expected 1/0/80005000", a_arready, b_arready, o_araddr); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    i_areset = 1;
    test_reset();
    test_read_tie();
    test_round_robin();
    test_write_order();
    test_concurrency();
    test_mid_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
